qsys_block_nios_ocimem_ctrl: RTL and testbench
==============================================

QSYS_BLOCK_NIOS_OCIMEM_CTRL -- requirements
Module: qsys_block_nios_ocimem_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width of the debug RAM (legal 4..14); depth = 2**ADDR_W words of 32 bits.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
REQ-004 jdo  in  38  JTAG data from the debug-module sysclk stage, valid while any take_* strobe is high.
REQ-005 take_action_ocimem_a  in  1  one-cycle strobe: address load, with optional read.
REQ-006 take_no_action_ocimem_a  in  1  one-cycle strobe: address increment, then read.
REQ-007 take_action_ocimem_b  in  1  one-cycle strobe: write, then address increment.
REQ-008 avs_address  in  ADDR_W  CPU word address.
REQ-009 avs_read, avs_write  in  1 each  CPU read and write requests.
REQ-010 avs_writedata  in  32  CPU write data.
REQ-011 avs_byteenable  in  4  CPU byte lanes.
REQ-012 avs_readdata  out  32  CPU read data; fixed read latency of 1 cycle after acceptance.
REQ-013 avs_waitrequest  out  1  CPU stall.
REQ-014 MonDReg  out  32  JTAG read-data register, fed back to the debug-module tck stage.
REQ-015 monitor_ready  out  1  JTAG read data in MonDReg is valid.
REQ-016 monitor_error  out  1  sticky flag: a JTAG command was dropped (overrun).

Function
REQ-017 Debug RAM shall be single-port, synchronous-read, 2**ADDR_W x 32; JTAG and CPU share the port.
REQ-018 JTAG address register jaddr shall be ADDR_W bits wide.
REQ-019 Command decode, in priority order when more than one strobe is high: ocimem_b, then ocimem_a, then no_action_ocimem_a.
REQ-020 ocimem_a: jaddr <= jdo[17+ADDR_W:18]; if jdo[17]=1, start a JTAG read at the new jaddr, else return to IDLE after 1 cycle; monitor_error <= 0.
REQ-021 no_action_ocimem_a: jaddr <= jaddr+1, wrapping from all-ones to 0; start a JTAG read at the incremented address.
REQ-022 ocimem_b: write jdo[34:3] to RAM[jaddr] with all byte lanes enabled; then jaddr <= jaddr+1 (wrapping).
REQ-023 FSM states: IDLE, JLD, JRD, JCAP, JWR.
  - IDLE -> JLD on ocimem_a with jdo[17]=0.
  - IDLE -> JRD on ocimem_a with jdo[17]=1, or on no_action_ocimem_a.
  - IDLE -> JWR on ocimem_b.
  - JLD -> IDLE.
  - JRD -> JCAP.
  - JCAP -> IDLE.
  - JWR -> IDLE.
REQ-024 JTAG read timing: command sampled at edge E; RAM addressed in state JRD; at edge E+2 MonDReg <= RAM data and monitor_ready <= 1.
REQ-025 monitor_ready shall clear at the edge that accepts any JTAG command and stay 0 until the capture edge.
REQ-026 JTAG write timing: the RAM write occurs at edge E+1 (state JWR); jaddr increments at that same edge.
REQ-027 A JTAG strobe arriving while the FSM is not IDLE shall be ignored (no effect on jaddr, RAM or MonDReg) and shall set monitor_error.
REQ-028 monitor_error is sticky; it clears only via REQ-020 or reset.
REQ-029 avs_waitrequest = (FSM != IDLE) OR (any JTAG strobe this cycle); it is combinational and may be asserted regardless of avs_read/avs_write.
REQ-030 A CPU access is accepted when (avs_read OR avs_write) AND NOT avs_waitrequest.
REQ-031 Accepted CPU write: update only the bytes enabled by avs_byteenable.
REQ-032 Accepted CPU read: avs_readdata valid exactly 1 cycle later; avs_readdata holds its value otherwise.
REQ-033 avs_read and avs_write high together: treat as a write; no read data is returned.
REQ-034 JTAG always wins the port: a CPU request coincident with a JTAG strobe is stalled, never dropped.
REQ-035 A CPU read followed immediately by a write to the same address shall return the old data.

Reset
REQ-036 Asynchronous reset assertion shall force: FSM=IDLE, jaddr=0, MonDReg=0, monitor_ready=0, monitor_error=0, avs_readdata=0, avs_waitrequest=0.
REQ-037 RAM contents are not reset.
REQ-038 A reset asserted mid-operation (in JRD, JCAP or JWR) shall abort the operation with no capture; a write not yet at its edge is lost.
REQ-039 Reset deassertion is synchronized by the system; the first command is accepted at the first edge after release.

Verification
REQ-040 JTAG write then read: ocimem_a jdo[25:18]=0x05, jdo[17]=0; then ocimem_b jdo[34:3]=0xDEADBEEF; then ocimem_a addr 0x05, rd=1 -> MonDReg=0xDEADBEEF and monitor_ready=1 at E+2; jaddr=0x05.
REQ-041 Wrap: load jaddr=0xFF, issue no_action_ocimem_a -> read of RAM[0x00]; jaddr=0x00.
REQ-042 Overrun: ocimem_a rd=1 followed by ocimem_b on the next cycle -> the write is dropped, RAM unchanged, monitor_error=1; the next ocimem_a clears monitor_error.
REQ-043 Contention: CPU write to 0x10 asserted in the same cycle as a JTAG strobe -> waitrequest=1 for 2 cycles, then the write completes; a CPU read of 0x10 returns the written value after 1 cycle.
REQ-044 Byte enables: RAM[3]=0x11223344, CPU write 0xAABBCCDD with avs_byteenable=4'b0101 -> RAM[3]=0x11BB33DD.
REQ-045 Reset asserted in state JRD -> monitor_ready stays 0, MonDReg=0, FSM=IDLE, waitrequest=0 immediately.

Source files
------------

// File: rtl/qsys_block_nios_ocimem_ctrl.sv
// rtl/qsys_block_nios_ocimem_ctrl.sv - Nios debug RAM shared between the JTAG debug path and the CPU slave port
// JTAG commands own the single RAM port for their whole sequence; the CPU is stalled meanwhile.
module qsys_block_nios_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {IDLE, JLD, JRD, JCAP, JWR} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] jaddr_q;
  logic [31:0]       jwdata_q;
  logic [31:0]       mon_q;
  logic              ready_q;
  logic              error_q;

  logic [31:0]       mem [0:(2**ADDR_W)-1];
  logic [31:0]       ram_rdata_q;
  logic              rd_vld_q;
  logic [31:0]       rd_hold_q;

  logic              jtag_cmd;
  logic              cpu_acc;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign jtag_cmd        = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign avs_waitrequest = (state_q != IDLE) | jtag_cmd;
  assign cpu_acc         = (avs_read | avs_write) & ~avs_waitrequest;
  assign cpu_wr          = cpu_acc & avs_write;
  assign cpu_rd          = cpu_acc & ~avs_write;

  always_comb begin
    ram_addr  = avs_address;
    ram_we    = cpu_wr;
    ram_re    = cpu_rd;
    ram_wdata = avs_writedata;
    ram_be    = avs_byteenable;
    if (state_q == JWR) begin
      ram_addr  = jaddr_q;
      ram_we    = 1'b1;
      ram_re    = 1'b0;
      ram_wdata = jwdata_q;
      ram_be    = 4'hF;
    end else if (state_q == JRD) begin
      ram_addr  = jaddr_q;
      ram_we    = 1'b0;
      ram_re    = 1'b1;
    end
  end

  // Single-port synchronous RAM; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end else if (ram_re) begin
      ram_rdata_q <= mem[ram_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q  <= 1'b0;
      rd_hold_q <= 32'h0;
    end else begin
      rd_vld_q <= cpu_rd;
      if (rd_vld_q) rd_hold_q <= ram_rdata_q;
    end
  end

  // Fresh RAM data in the cycle after a CPU read, the last CPU result otherwise.
  assign avs_readdata = rd_vld_q ? ram_rdata_q : rd_hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      jaddr_q  <= '0;
      jwdata_q <= 32'h0;
      mon_q    <= 32'h0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (take_action_ocimem_b) begin
        jwdata_q <= jdo[34:3];
        ready_q  <= 1'b0;
        state_q  <= JWR;
      end else if (take_action_ocimem_a) begin
        jaddr_q  <= jdo[17+ADDR_W:18];
        error_q  <= 1'b0;
        ready_q  <= 1'b0;
        state_q  <= jdo[17] ? JRD : JLD;
      end else if (take_no_action_ocimem_a) begin
        jaddr_q  <= jaddr_q + ADDR_W'(1);
        ready_q  <= 1'b0;
        state_q  <= JRD;
      end
    end else begin
      if (jtag_cmd) error_q <= 1'b1;
      case (state_q)
        JRD:  state_q <= JCAP;
        JCAP: begin
          mon_q   <= ram_rdata_q;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        JWR: begin
          jaddr_q <= jaddr_q + ADDR_W'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_qsys_block_nios_ocimem_ctrl.sv
// tb/tb_qsys_block_nios_ocimem_ctrl.sv - scoreboard bench for the debug RAM controller
// Stimulus pushes expected read data; a monitor pops on monitor_ready rise or an accepted CPU read.
module tb_qsys_block_nios_ocimem_ctrl;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [AW-1:0] avs_address;
  logic          avs_read, avs_write;
  logic [31:0]   avs_writedata;
  logic [3:0]    avs_byteenable;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;

  int n_err = 0;
  int n_checks = 0;
  logic [31:0] exp_mon[$];
  logic [31:0] exp_cpu[$];
  logic        prev_ready = 1'b0;
  logic        cpu_pend = 1'b0;

  qsys_block_nios_ocimem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: CPU read acceptance is observed at the edge, data checked half a cycle later.
  always @(posedge clk) cpu_pend <= avs_read && !avs_write && !avs_waitrequest && !reset;

  always @(negedge clk) begin
    if (monitor_ready && !prev_ready) begin
      if (exp_mon.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL mon_unexpected: got %h expected none", MonDReg);
      end else check("mondreg", MonDReg, exp_mon.pop_front());
    end
    prev_ready <= monitor_ready;
    if (cpu_pend) begin
      if (exp_cpu.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL cpu_unexpected: got %h expected none", avs_readdata);
      end else check("readdata", avs_readdata, exp_cpu.pop_front());
    end
  end

  function automatic logic [37:0] jd_a(input logic [AW-1:0] addr, input logic rd);
    logic [37:0] d = '0;
    d[17+AW:18] = addr;
    d[17] = rd;
    return d;
  endfunction

  function automatic logic [37:0] jd_b(input logic [31:0] data);
    logic [37:0] d = '0;
    d[34:3] = data;
    return d;
  endfunction

  task automatic jtag_cmd(input logic a, input logic na, input logic b, input logic [37:0] d);
    @(negedge clk);
    take_action_ocimem_a = a; take_no_action_ocimem_a = na; take_action_ocimem_b = b; jdo = d;
    @(negedge clk);
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0; jdo = '0;
  endtask

  task automatic jtag_load(input logic [AW-1:0] addr);
    jtag_cmd(1, 0, 0, jd_a(addr, 1'b0));
    @(negedge clk);
  endtask

  task automatic jtag_write(input logic [31:0] data);
    jtag_cmd(0, 0, 1, jd_b(data));
    @(negedge clk);
  endtask

  task automatic jtag_read(input logic [AW-1:0] addr, input logic [31:0] exp);
    exp_mon.push_back(exp);
    jtag_cmd(1, 0, 0, jd_a(addr, 1'b1));
    repeat (2) @(negedge clk);
  endtask

  task automatic jtag_next(input logic [31:0] exp);
    exp_mon.push_back(exp);
    jtag_cmd(0, 1, 0, '0);
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    avs_write = 1; avs_address = addr; avs_writedata = data; avs_byteenable = be;
    @(negedge clk);
    avs_write = 0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] addr, input logic [31:0] exp);
    @(negedge clk);
    avs_read = 1; avs_address = addr;
    exp_cpu.push_back(exp);
    @(negedge clk);
    avs_read = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; jdo = '0;
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
    repeat (3) @(negedge clk);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_ready", monitor_ready, 1'b0);
    check("rst_error", monitor_error, 1'b0);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_wait", avs_waitrequest, 1'b0);
    reset = 0;

    // JTAG write then read back, with capture timing
    jtag_load(8'h05);
    jtag_write(32'hDEADBEEF);
    check("jaddr_after_write", dut.jaddr_q, 32'h06);
    exp_mon.push_back(32'hDEADBEEF);
    jtag_cmd(1, 0, 0, jd_a(8'h05, 1'b1));
    check("ready_e1", monitor_ready, 1'b0);
    check("wait_jrd", avs_waitrequest, 1'b1);
    @(negedge clk);
    check("ready_e2", monitor_ready, 1'b0);
    @(negedge clk);
    check("ready_cap", monitor_ready, 1'b1);
    check("jaddr_after_read", dut.jaddr_q, 32'h05);

    // Address wrap on increment-and-read
    jtag_load(8'h00);
    jtag_write(32'h12345678);
    jtag_load(8'hFF);
    jtag_next(32'h12345678);
    check("jaddr_wrap", dut.jaddr_q, 32'h00);

    // Overrun: a write strobe during a read is dropped
    exp_mon.push_back(32'hDEADBEEF);
    @(negedge clk);
    take_action_ocimem_a = 1; jdo = jd_a(8'h05, 1'b1);
    @(negedge clk);
    take_action_ocimem_a = 0; take_action_ocimem_b = 1; jdo = jd_b(32'hCAFEF00D);
    @(negedge clk);
    take_action_ocimem_b = 0; jdo = '0;
    check("overrun_error", monitor_error, 1'b1);
    @(negedge clk);
    check("overrun_jaddr", dut.jaddr_q, 32'h05);
    check("error_sticky", monitor_error, 1'b1);
    jtag_read(8'h05, 32'hDEADBEEF);
    check("error_cleared", monitor_error, 1'b0);

    // Contention: CPU write stalled behind a JTAG address load
    @(negedge clk);
    avs_write = 1; avs_address = 8'h10; avs_writedata = 32'h0BADF00D; avs_byteenable = 4'hF;
    take_action_ocimem_a = 1; jdo = jd_a(8'h20, 1'b0);
    #1 check("cont_wait0", avs_waitrequest, 1'b1);
    @(negedge clk);
    take_action_ocimem_a = 0; jdo = '0;
    check("cont_wait1", avs_waitrequest, 1'b1);
    @(negedge clk);
    check("cont_wait2", avs_waitrequest, 1'b0);
    @(negedge clk);
    avs_write = 0;
    cpu_read(8'h10, 32'h0BADF00D);

    // Byte enables, read-before-write ordering, read+write collision
    cpu_write(8'h03, 32'h11223344, 4'hF);
    cpu_write(8'h03, 32'hAABBCCDD, 4'b0101);
    cpu_read(8'h03, 32'h11BB33DD);
    @(negedge clk);
    avs_read = 1; avs_address = 8'h03; exp_cpu.push_back(32'h11BB33DD);
    @(negedge clk);
    avs_read = 0; avs_write = 1; avs_writedata = 32'h55667788; avs_byteenable = 4'hF;
    @(negedge clk);
    avs_write = 0;
    cpu_read(8'h03, 32'h55667788);
    @(negedge clk);
    avs_read = 1; avs_write = 1; avs_writedata = 32'h01020304;
    @(negedge clk);
    avs_read = 0; avs_write = 0;
    @(negedge clk);
    check("readdata_hold", avs_readdata, 32'h55667788);
    cpu_read(8'h03, 32'h01020304);

    // Reset while in JRD aborts the capture
    jtag_cmd(1, 0, 0, jd_a(8'h07, 1'b1));
    reset = 1;
    #1;
    check("rjrd_ready", monitor_ready, 1'b0);
    check("rjrd_mondreg", MonDReg, 32'h0);
    check("rjrd_wait", avs_waitrequest, 1'b0);
    check("rjrd_readdata", avs_readdata, 32'h0);
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    check("rjrd_ready_after", monitor_ready, 1'b0);
    check("rjrd_jaddr", dut.jaddr_q, 32'h0);

    repeat (2) @(negedge clk);
    check("mon_queue_empty", exp_mon.size(), 32'd0);
    check("cpu_queue_empty", exp_cpu.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
